// File: rtl/button_cmd_arbiter_if.sv
// Handshake bundle between the pushbutton arbiter (master) and the processor control unit (slave).
// Carries the raw button levels in and the command offer, busy flag and pending mask out.
interface button_cmd_arbiter_if #(
    parameter int N_BTN = 4
);
    localparam int IDW = (N_BTN > 1) ? $clog2(N_BTN) : 1;

    logic [N_BTN-1:0] btn;
    logic             cmd_ready;
    logic             done;
    logic             cmd_valid;
    logic [IDW-1:0]   cmd_id;
    logic             busy;
    logic [N_BTN-1:0] pending;

    modport master (
        input  btn, cmd_ready, done,
        output cmd_valid, cmd_id, busy, pending
    );

    modport slave (
        output btn, cmd_ready, done,
        input  cmd_valid, cmd_id, busy, pending
    );
endinterface

// File: rtl/button_cmd_arbiter.sv
// Debounces synchronized pushbuttons, latches presses as pending requests and issues them one at a
// time by fixed priority (bit 0 highest). Macro SIM_FAST_DEBOUNCE_EN shrinks the debounce time to 2 cycles.
module button_cmd_arbiter #(
    parameter int N_BTN      = 4,
    parameter int DEB_CYCLES = 250000
) (
    input  logic                 clk,
    input  logic                 rst,
    button_cmd_arbiter_if.master arb_if
);
    localparam int IDW = (N_BTN > 1) ? $clog2(N_BTN) : 1;
`ifdef SIM_FAST_DEBOUNCE_EN
    localparam int T  = 2;
    localparam int CW = 1;
`else
    localparam int T  = DEB_CYCLES;
    localparam int CW = $clog2(DEB_CYCLES + 1);
`endif
    localparam logic [CW-1:0] CNT_LAST = CW'(T - 1);

    typedef enum logic [1:0] {IDLE, OFFER, WAIT} state_t;

    logic [CW-1:0]    cnt_q [N_BTN];
    logic [CW-1:0]    cnt_d [N_BTN];
    logic [N_BTN-1:0] stable_q, stable_d;
    logic [N_BTN-1:0] pending_q, pending_d;
    logic [N_BTN-1:0] rise, clr;
    logic [IDW-1:0]   first_idx;
    logic             handshake;

    state_t           state_q;
    logic             cmd_valid_q;
    logic [IDW-1:0]   cmd_id_q;
    logic             busy_q;

    // A level is accepted only after it has differed from the stable level for T consecutive cycles
    always_comb begin
        for (int i = 0; i < N_BTN; i++) begin
            cnt_d[i]    = cnt_q[i];
            stable_d[i] = stable_q[i];
            if (arb_if.btn[i] != stable_q[i]) begin
                if (cnt_q[i] == CNT_LAST) begin
                    stable_d[i] = arb_if.btn[i];
                    cnt_d[i]    = '0;
                end else begin
                    cnt_d[i] = cnt_q[i] + CW'(1);
                end
            end else begin
                cnt_d[i] = '0;
            end
        end
        rise = stable_d & ~stable_q;
    end

    // A press landing on the handshake edge of its own index is kept, so it gets served again
    always_comb begin
        handshake = (state_q == OFFER) && arb_if.cmd_ready;
        clr       = handshake ? (N_BTN'(1) << cmd_id_q) : '0;
        pending_d = (pending_q & ~clr) | rise;
        first_idx = '0;
        for (int i = N_BTN - 1; i >= 0; i--) begin
            if (pending_q[i]) begin
                first_idx = IDW'(i);
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < N_BTN; i++) begin
                cnt_q[i] <= '0;
            end
            stable_q  <= '0;
            pending_q <= '0;
        end else begin
            for (int i = 0; i < N_BTN; i++) begin
                cnt_q[i] <= cnt_d[i];
            end
            stable_q  <= stable_d;
            pending_q <= pending_d;
        end
    end

    // Non-preemptive: the index is latched once in IDLE and held until the processor reports done
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            cmd_valid_q <= 1'b0;
            cmd_id_q    <= '0;
            busy_q      <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (|pending_q) begin
                        state_q     <= OFFER;
                        cmd_id_q    <= first_idx;
                        cmd_valid_q <= 1'b1;
                        busy_q      <= 1'b1;
                    end
                end
                OFFER: begin
                    if (arb_if.cmd_ready) begin
                        state_q     <= WAIT;
                        cmd_valid_q <= 1'b0;
                    end
                end
                WAIT: begin
                    if (arb_if.done) begin
                        state_q <= IDLE;
                        busy_q  <= 1'b0;
                    end
                end
                default: begin
                    state_q     <= IDLE;
                    cmd_valid_q <= 1'b0;
                    busy_q      <= 1'b0;
                end
            endcase
        end
    end

    assign arb_if.cmd_valid = cmd_valid_q;
    assign arb_if.cmd_id    = cmd_id_q;
    assign arb_if.busy      = busy_q;
    assign arb_if.pending   = pending_q;
endmodule

// File: tb/tb_button_cmd_arbiter.sv
// Self-checking bench for button_cmd_arbiter: directed scenarios with literal expectations,
// then random button/ready/done traffic compared every cycle against a history-based model.
module tb_button_cmd_arbiter;
   localparam int N_BTN = 4;
   localparam int DEB   = 4;
`ifdef SIM_FAST_DEBOUNCE_EN
   localparam int T = 2;
`else
   localparam int T = DEB;
`endif
   localparam logic [31:0] histMask = (32'd1 << T) - 32'd1;

   logic clk = 1'b0;
   logic rst = 1'b1;
   int   checkCount = 0;
   int   passCount  = 0;

   always #5 clk = ~clk;

   button_cmd_arbiter_if #(.N_BTN(N_BTN)) arbIf();

   button_cmd_arbiter #(.N_BTN(N_BTN), .DEB_CYCLES(DEB)) dut (
      .clk    (clk),
      .rst    (rst),
      .arb_if (arbIf)
   );

   task automatic checkOutput(input string name, input int actual, input int expected);
      checkCount++;
      if (actual == expected) passCount++;
      else $display("[TB] FAIL %s: got %0d, expected %0d at time %0t", name, actual, expected, $time);
   endtask

   task automatic applyStimulus(input logic [N_BTN-1:0] b, input logic rdy, input logic dn);
      arbIf.btn       = b;
      arbIf.cmd_ready = rdy;
      arbIf.done      = dn;
   endtask

   task automatic waitEdges(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic pulseDone();
      @(negedge clk);
      arbIf.done = 1'b1;
      @(negedge clk);
      arbIf.done = 1'b0;
   endtask

   // Model: a button's accepted level flips once its last T raw samples all disagree with it.
   // Command flow is tracked as phase 0 = nothing offered, 1 = offering mId, 2 = awaiting done.
   logic [31:0]      mHist [N_BTN];
   logic [N_BTN-1:0] mStable;
   logic [N_BTN-1:0] mPend;
   int               mPhase;
   int               mId;

   function automatic int lowestSet(input logic [N_BTN-1:0] v);
      for (int i = 0; i < N_BTN; i++) if (v[i]) return i;
      return 0;
   endfunction

   always @(posedge clk or posedge rst) begin
      logic [N_BTN-1:0] newPress;
      logic [N_BTN-1:0] taken;
      if (rst) begin
         for (int i = 0; i < N_BTN; i++) mHist[i] = 32'd0;
         mStable = '0;
         mPend   = '0;
         mPhase  = 0;
         mId     = 0;
      end else begin
         newPress = '0;
         taken    = '0;
         for (int i = 0; i < N_BTN; i++) begin
            mHist[i] = {mHist[i][30:0], arbIf.btn[i]};
            if (!mStable[i] && ((mHist[i] & histMask) == histMask)) begin
               mStable[i]  = 1'b1;
               newPress[i] = 1'b1;
            end else if (mStable[i] && ((mHist[i] & histMask) == 32'd0)) begin
               mStable[i] = 1'b0;
            end
         end
         case (mPhase)
            0: if (mPend != '0) begin mId = lowestSet(mPend); mPhase = 1; end
            1: if (arbIf.cmd_ready) begin taken[mId] = 1'b1; mPhase = 2; end
            default: if (arbIf.done) mPhase = 0;
         endcase
         mPend = (mPend & ~taken) | newPress;
      end
   end

   always @(negedge clk) begin
      if (!rst) begin
         checkOutput("cmd_valid", int'(arbIf.cmd_valid), int'(mPhase == 1));
         checkOutput("busy", int'(arbIf.busy), int'(mPhase != 0));
         checkOutput("pending", int'(arbIf.pending), int'(mPend));
         if (mPhase == 1) checkOutput("cmd_id", int'(arbIf.cmd_id), mId);
      end
   end

   initial begin
      applyStimulus(4'b0000, 1'b0, 1'b0);
      #1;
      checkOutput("reset cmd_valid", int'(arbIf.cmd_valid), 0);
      checkOutput("reset busy", int'(arbIf.busy), 0);
      checkOutput("reset pending", int'(arbIf.pending), 0);
      checkOutput("reset cmd_id", int'(arbIf.cmd_id), 0);
      repeat (2) @(negedge clk);
      rst = 1'b0;

      // Glitch one cycle shorter than the debounce time
      @(negedge clk);
      applyStimulus(4'b0001, 1'b0, 1'b0);
      repeat (T - 1) @(negedge clk);
      arbIf.btn = 4'b0000;
      waitEdges(2 * T + 2);
      checkOutput("glitch pending", int'(arbIf.pending), 0);
      checkOutput("glitch cmd_valid", int'(arbIf.cmd_valid), 0);

      // Single press with ready already high
      @(negedge clk);
      applyStimulus(4'b0010, 1'b1, 1'b0);
      waitEdges(T);
      checkOutput("single pending", int'(arbIf.pending), 2);
      checkOutput("single no early valid", int'(arbIf.cmd_valid), 0);
      waitEdges(1);
      checkOutput("single cmd_valid", int'(arbIf.cmd_valid), 1);
      checkOutput("single cmd_id", int'(arbIf.cmd_id), 1);
      waitEdges(1);
      checkOutput("single valid one cycle", int'(arbIf.cmd_valid), 0);
      checkOutput("single pending cleared", int'(arbIf.pending), 0);
      waitEdges(3);
      checkOutput("single busy in wait", int'(arbIf.busy), 1);
      pulseDone();
      checkOutput("single busy after done", int'(arbIf.busy), 0);
      arbIf.btn = 4'b0000;
      repeat (T + 3) @(negedge clk);

      // Two simultaneous presses: lower index first, then an idle cycle
      applyStimulus(4'b1100, 1'b1, 1'b0);
      waitEdges(T + 1);
      checkOutput("prio first valid", int'(arbIf.cmd_valid), 1);
      checkOutput("prio first id", int'(arbIf.cmd_id), 2);
      waitEdges(1);
      checkOutput("prio pending left", int'(arbIf.pending), 8);
      pulseDone();
      checkOutput("prio idle busy", int'(arbIf.busy), 0);
      checkOutput("prio idle valid", int'(arbIf.cmd_valid), 0);
      waitEdges(1);
      checkOutput("prio second valid", int'(arbIf.cmd_valid), 1);
      checkOutput("prio second id", int'(arbIf.cmd_id), 3);
      waitEdges(1);
      pulseDone();
      arbIf.btn = 4'b0000;
      repeat (T + 3) @(negedge clk);

      // Backpressure: offer must hold steady until ready rises
      applyStimulus(4'b0001, 1'b0, 1'b0);
      waitEdges(T + 1);
      for (int k = 0; k < 20; k++) begin
         checkOutput("bp valid held", int'(arbIf.cmd_valid), 1);
         checkOutput("bp id held", int'(arbIf.cmd_id), 0);
         waitEdges(1);
      end
      @(negedge clk);
      arbIf.cmd_ready = 1'b1;
      waitEdges(1);
      checkOutput("bp handshake valid", int'(arbIf.cmd_valid), 0);
      checkOutput("bp handshake pending", int'(arbIf.pending), 0);
      checkOutput("bp busy in wait", int'(arbIf.busy), 1);
      pulseDone();
      arbIf.btn = 4'b0000;
      repeat (T + 3) @(negedge clk);

      // Reset while waiting for done, button 0 still held
      applyStimulus(4'b0011, 1'b1, 1'b0);
      waitEdges(T + 1);
      checkOutput("rst offer id", int'(arbIf.cmd_id), 0);
      waitEdges(1);
      checkOutput("rst wait pending", int'(arbIf.pending), 2);
      @(negedge clk);
      #2 rst = 1'b1;
      #1;
      checkOutput("async rst valid", int'(arbIf.cmd_valid), 0);
      checkOutput("async rst busy", int'(arbIf.busy), 0);
      checkOutput("async rst pending", int'(arbIf.pending), 0);
      @(negedge clk);
      rst = 1'b0;
      waitEdges(T);
      checkOutput("rst re-press pending", int'(arbIf.pending), 3);
      waitEdges(1);
      checkOutput("rst re-offer valid", int'(arbIf.cmd_valid), 1);
      checkOutput("rst re-offer id", int'(arbIf.cmd_id), 0);

      // Random traffic against the model
      for (int c = 0; c < 3000; c++) begin
         @(negedge clk);
         for (int i = 0; i < N_BTN; i++) begin
            if ($urandom_range(0, 7) == 0) arbIf.btn[i] = ~arbIf.btn[i];
         end
         arbIf.cmd_ready = ($urandom_range(0, 1) == 1);
         arbIf.done      = ($urandom_range(0, 3) == 0);
      end
      @(negedge clk);
      $display("[TB] %0d/%0d checks passed", passCount, checkCount);
      $finish;
   end
endmodule
